// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

  // Run sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dm_state_e;

  // Stages between acceptance and the read-return pulse
  localparam int RD_PIPE_DEPTH = 2;

  localparam int DEF_N_CORES = 4;
  localparam int DEF_AW      = 12;
  localparam int DEF_DW      = 12;

  // Pointer width that stays legal for a single core
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// rtl/dm_arbiter_rr_pick.sv - one-hot winner picker; DM_ARB_FIXED_PRI_EN selects fixed priority
module rr_pick
  import dm_arb_pkg::*;
#(
  parameter int N  = DEF_N_CORES,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_mask,
`ifndef DM_ARB_FIXED_PRI_EN
  input  logic [PW-1:0] ptr,
`endif
  output logic [N-1:0]  win
);

`ifdef DM_ARB_FIXED_PRI_EN
  logic found;

  // Lowest set index wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_mask[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`else
  logic found;
  int   idx;

  // Search from ptr upward, wrapping at N; first requester found wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_mask[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - shared data-memory arbiter top; build option DM_ARB_FIXED_PRI_EN
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_CORES-1:0]    core_done,
  input  logic [N_CORES-1:0]    req,
  input  logic [N_CORES-1:0]    we,
  input  logic [N_CORES*AW-1:0] addr,
  input  logic [N_CORES*DW-1:0] wdata,
  output logic [N_CORES-1:0]    gnt,
  output logic [N_CORES-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  busy,
  output logic                  all_done
);

  localparam int PW = ptr_width(N_CORES);

  dm_state_e          state, state_nxt;
  logic [N_CORES-1:0] req_mask;
  logic               accept;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;
  logic [N_CORES-1:0] rd_new;
  logic [N_CORES-1:0] rd_pipe [RD_PIPE_DEPTH];
  logic               in_flight;

  // Only live, unfinished cores may compete, and only while running
  assign req_mask = (state == ST_RUN) ? (req & ~core_done) : '0;

`ifdef DM_ARB_FIXED_PRI_EN
  rr_pick #(.N(N_CORES), .PW(PW)) u_pick (
    .req_mask (req_mask),
    .win      (gnt)
  );
`else
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;

  rr_pick #(.N(N_CORES), .PW(PW)) u_pick (
    .req_mask (req_mask),
    .ptr      (ptr),
    .win      (gnt)
  );

  // Pointer moves to the core after the accepted one
  always_comb begin
    ptr_nxt = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (gnt[k]) ptr_nxt = (k == N_CORES - 1) ? '0 : PW'(k + 1);
    end
  end

  // Round-robin pointer register, holds when nothing is accepted
  always_ff @(posedge clk) begin
    if (rst)         ptr <= '0;
    else if (accept) ptr <= ptr_nxt;
  end
`endif

  // A grant is only ever raised on a requesting core, so any grant is an acceptance
  assign accept = |gnt;

  // Select the winning core's command fields
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < N_CORES; k++) begin
      if (gnt[k]) begin
        sel_we    = we[k];
        sel_addr  = addr[k*AW +: AW];
        sel_wdata = wdata[k*DW +: DW];
      end
    end
  end

  // Reads carry their requester's one-hot tag down the return pipeline
  assign rd_new = (accept && !sel_we) ? gnt : '0;

  // Any tag still travelling means the run cannot be reported done
  always_comb begin
    in_flight = 1'b0;
    for (int s = 0; s < RD_PIPE_DEPTH; s++) begin
      in_flight = in_flight | (|rd_pipe[s]);
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Sequencer next state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    all_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (&core_done) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!in_flight) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        all_done = 1'b1;
        if (start) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered memory command, issued the cycle after acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= accept;
      if (accept) begin
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

  // Read-return tag pipeline; reset drops any read in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_PIPE_DEPTH; s++) rd_pipe[s] <= '0;
    end else begin
      rd_pipe[0] <= rd_new;
      for (int s = 1; s < RD_PIPE_DEPTH; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
  end

  assign rvalid = rd_pipe[RD_PIPE_DEPTH-1];
  assign rdata  = (|rvalid) ? mem_rdata : '0;

endmodule
